// File: rtl/dice_tid_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : dice_tid_dispatcher
// Purpose  : Issues LANES linear thread IDs plus raster (x,y,z) coordinates per
//            beat for one CTA over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dice_tid_dispatcher #(
    parameter int TOTAL_TID = 512,
    parameter int TID_WIDTH = $clog2(TOTAL_TID),
    parameter int LANES     = 1,
    parameter int CNT_WIDTH = TID_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         start,
    input  logic                         enable,
    input  logic [TID_WIDTH-1:0]         max_tid,
    input  logic [TID_WIDTH-1:0]         ntid_x,
    input  logic [TID_WIDTH-1:0]         ntid_y,
    input  logic [TID_WIDTH-1:0]         ntid_z,
    input  logic                         ready,
    output logic                         valid,
    output logic [LANES-1:0]             lane_mask,
    output logic [LANES*TID_WIDTH-1:0]   dispatch_tid,
    output logic [LANES*TID_WIDTH-1:0]   tid_x,
    output logic [LANES*TID_WIDTH-1:0]   tid_y,
    output logic [LANES*TID_WIDTH-1:0]   tid_z,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_WIDTH-1:0]         issued_count
);

    localparam int W  = TID_WIDTH + 1;
    localparam int FW = LANES * TID_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [TID_WIDTH-1:0]   max_q, max_d, nx_q, nx_d, ny_q, ny_d, nz_q, nz_d;
    logic [W-1:0]           base_q, base_d;
    logic [TID_WIDTH-1:0]   bx_q, bx_d, by_q, by_d, bz_q, bz_d;
    logic                   last_q, last_d;
    logic                   valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic [LANES-1:0]       mask_q, mask_d;
    logic [FW-1:0]          tid_q, tid_d, x_q, x_d, y_q, y_d, z_q, z_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    // Beat candidate built from the base counters
    logic [W-1:0]           w_t;
    logic [TID_WIDTH-1:0]   w_cx, w_cy, w_cz;
    logic [LANES-1:0]       w_mask;
    logic [FW-1:0]          w_tid, w_x, w_y, w_z;
    logic                   w_last;
    logic [CNT_WIDTH-1:0]   w_pop;
    logic                   w_acc;

    always_comb begin
        w_t    = '0;
        w_cx   = bx_q;
        w_cy   = by_q;
        w_cz   = bz_q;
        w_mask = '0;
        w_tid  = '0;
        w_x    = '0;
        w_y    = '0;
        w_z    = '0;
        for (int l = 0; l < LANES; l++) begin
            w_t = base_q + W'(l);
            if (w_t <= {1'b0, max_q}) begin
                w_mask[l]                           = 1'b1;
                w_tid[l*TID_WIDTH +: TID_WIDTH]     = w_t[TID_WIDTH-1:0];
                w_x[l*TID_WIDTH +: TID_WIDTH]       = w_cx;
                w_y[l*TID_WIDTH +: TID_WIDTH]       = w_cy;
                w_z[l*TID_WIDTH +: TID_WIDTH]       = w_cz;
            end
            // After the last lane this leaves the next beat's base coordinates
            if (w_cx == nx_q) begin
                w_cx = '0;
                if (w_cy == ny_q) begin
                    w_cy = '0;
                    if (w_cz == nz_q) w_cz = '0;
                    else              w_cz = w_cz + TID_WIDTH'(1);
                end else begin
                    w_cy = w_cy + TID_WIDTH'(1);
                end
            end else begin
                w_cx = w_cx + TID_WIDTH'(1);
            end
        end
        w_last = (base_q + W'(LANES - 1)) >= {1'b0, max_q};
    end

    always_comb begin
        w_pop = '0;
        for (int l = 0; l < LANES; l++) begin
            w_pop = w_pop + CNT_WIDTH'(mask_q[l]);
        end
    end

    assign w_acc = valid_q && ready;

    always_comb begin
        state_d = state_q;
        max_d   = max_q;
        nx_d    = nx_q;
        ny_d    = ny_q;
        nz_d    = nz_q;
        base_d  = base_q;
        bx_d    = bx_q;
        by_d    = by_q;
        bz_d    = bz_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        mask_d  = mask_q;
        tid_d   = tid_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    max_d   = max_tid;
                    nx_d    = ntid_x;
                    ny_d    = ntid_y;
                    nz_d    = ntid_z;
                    base_d  = '0;
                    bx_d    = '0;
                    by_d    = '0;
                    bz_d    = '0;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    mask_d  = '0;
                    tid_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    z_d     = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (w_acc) cnt_d = cnt_q + w_pop;
                if (w_acc && last_q) begin
                    state_d = S_DONE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    mask_d  = '0;
                    tid_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    z_d     = '0;
                end else if (!valid_q || w_acc) begin
                    // A presented beat is never retracted; enable only gates new beats
                    if (enable) begin
                        valid_d = 1'b1;
                        last_d  = w_last;
                        mask_d  = w_mask;
                        tid_d   = w_tid;
                        x_d     = w_x;
                        y_d     = w_y;
                        z_d     = w_z;
                        base_d  = base_q + W'(LANES);
                        bx_d    = w_cx;
                        by_d    = w_cy;
                        bz_d    = w_cz;
                    end else begin
                        valid_d = 1'b0;
                        mask_d  = '0;
                        tid_d   = '0;
                        x_d     = '0;
                        y_d     = '0;
                        z_d     = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q <= S_IDLE;
            max_q   <= '0;
            nx_q    <= '0;
            ny_q    <= '0;
            nz_q    <= '0;
            base_q  <= '0;
            bx_q    <= '0;
            by_q    <= '0;
            bz_q    <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mask_q  <= '0;
            tid_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            max_q   <= max_d;
            nx_q    <= nx_d;
            ny_q    <= ny_d;
            nz_q    <= nz_d;
            base_q  <= base_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            bz_q    <= bz_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mask_q  <= mask_d;
            tid_q   <= tid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid        = valid_q;
    assign lane_mask    = mask_q;
    assign dispatch_tid = tid_q;
    assign tid_x        = x_q;
    assign tid_y        = y_q;
    assign tid_z        = z_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign issued_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dice_tid_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_dice_tid_dispatcher
// Purpose  : Directed self-checking bench for dice_tid_dispatcher at 1, 4 and 8 lanes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dice_tid_dispatcher;

    localparam int TW = 9;
    localparam int CW = TW + 1;

    logic clk = 1'b0;
    logic rst, clr, start, enable, ready;
    logic [TW-1:0] max_tid, ntid_x, ntid_y, ntid_z;

    int nvec = 0;
    int nerr = 0;

    logic            v1, b1, d1;
    logic [0:0]      m1;
    logic [TW-1:0]   t1, x1, y1, z1;
    logic [CW-1:0]   c1;
    logic            v4, b4, d4;
    logic [3:0]      m4;
    logic [4*TW-1:0] t4, x4, y4, z4;
    logic [CW-1:0]   c4;
    logic            v8, b8, d8;
    logic [7:0]      m8;
    logic [8*TW-1:0] t8, x8, y8, z8;
    logic [CW-1:0]   c8;

    always #5 clk = ~clk;

    dice_tid_dispatcher #(.TOTAL_TID(512), .LANES(1)) u1 (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .enable(enable),
        .max_tid(max_tid), .ntid_x(ntid_x), .ntid_y(ntid_y), .ntid_z(ntid_z),
        .ready(ready), .valid(v1), .lane_mask(m1), .dispatch_tid(t1),
        .tid_x(x1), .tid_y(y1), .tid_z(z1), .busy(b1), .done(d1), .issued_count(c1));

    dice_tid_dispatcher #(.TOTAL_TID(512), .LANES(4)) u4 (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .enable(enable),
        .max_tid(max_tid), .ntid_x(ntid_x), .ntid_y(ntid_y), .ntid_z(ntid_z),
        .ready(ready), .valid(v4), .lane_mask(m4), .dispatch_tid(t4),
        .tid_x(x4), .tid_y(y4), .tid_z(z4), .busy(b4), .done(d4), .issued_count(c4));

    dice_tid_dispatcher #(.TOTAL_TID(512), .LANES(8)) u8 (
        .clk(clk), .rst(rst), .clr(clr), .start(start), .enable(enable),
        .max_tid(max_tid), .ntid_x(ntid_x), .ntid_y(ntid_y), .ntid_z(ntid_z),
        .ready(ready), .valid(v8), .lane_mask(m8), .dispatch_tid(t8),
        .tid_x(x8), .tid_y(y8), .tid_z(z8), .busy(b8), .done(d8), .issued_count(c8));

    // Reference coordinates by division, independent of the raster stepping
    function automatic int ex(int t, int nx);
        return t % (nx + 1);
    endfunction
    function automatic int ey(int t, int nx, int ny);
        return (t / (nx + 1)) % (ny + 1);
    endfunction
    function automatic int ez(int t, int nx, int ny, int nz);
        return (t / ((nx + 1) * (ny + 1))) % (nz + 1);
    endfunction

    task automatic do_start(input int mx, input int nx, input int ny, input int nz);
        clr = 1'b1;
        @(posedge clk); #1;
        clr     = 1'b0;
        max_tid = TW'(mx);
        ntid_x  = TW'(nx);
        ntid_y  = TW'(ny);
        ntid_z  = TW'(nz);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; start = 1'b0; enable = 1'b0; ready = 1'b0;
        max_tid = '0; ntid_x = '0; ntid_y = '0; ntid_z = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        nvec++; if (v4 !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", v4); end
        nvec++; if (b4 !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", b4); end
        nvec++; if (d4 !== 1'b0) begin nerr++; $display("FAIL reset_done: got %b want 0", d4); end
        nvec++; if (c4 !== '0) begin nerr++; $display("FAIL reset_count: got %0d want 0", c4); end
        nvec++; if (m4 !== 4'h0 || t4 !== '0 || x4 !== '0 || y4 !== '0 || z4 !== '0) begin
            nerr++; $display("FAIL reset_fields: got mask=%h tid=%h x=%h want all 0", m4, t4, x4);
        end
        enable = 1'b1;
        @(posedge clk); #1;
        nvec++; if (v4 !== 1'b0) begin nerr++; $display("FAIL idle_no_valid: got %b want 0", v4); end
    endtask

    task automatic test_lanes1();
        int e;
        enable = 1'b1; ready = 1'b1;
        do_start(255, 255, 0, 0);
        nvec++; if (v1 !== 1'b0) begin nerr++; $display("FAIL l1_valid_at_start: got %b want 0", v1); end
        e = 0;
        for (int cyc = 0; cyc < 400 && e < 256; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) begin
                nvec++; if (v1 !== 1'b1) begin nerr++; $display("FAIL l1_first_valid: got %b want 1", v1); end
            end
            if (v1) begin
                nvec++;
                if (t1 !== TW'(e) || x1 !== TW'(e) || y1 !== '0 || z1 !== '0 || m1 !== 1'b1) begin
                    nerr++;
                    $display("FAIL l1_beat: got tid=%0d x=%0d y=%0d z=%0d m=%b want tid=x=%0d y=z=0 m=1",
                             t1, x1, y1, z1, m1, e);
                end
                nvec++; if (c1 !== CW'(e)) begin nerr++; $display("FAIL l1_count: got %0d want %0d", c1, e); end
                e++;
            end
        end
        nvec++; if (e != 256) begin nerr++; $display("FAIL l1_timeout: got %0d beats want 256", e); end
        @(posedge clk); #1;
        nvec++; if (d1 !== 1'b1 || b1 !== 1'b0 || v1 !== 1'b0) begin
            nerr++; $display("FAIL l1_done: got done=%b busy=%b valid=%b want 1 0 0", d1, b1, v1);
        end
        nvec++; if (c1 !== CW'(256)) begin nerr++; $display("FAIL l1_final_count: got %0d want 256", c1); end
    endtask

    task automatic test_lanes4(input int mx, input int nx, input int ny, input int nz);
        int base, t;
        bit in;
        enable = 1'b1; ready = 1'b1;
        do_start(mx, nx, ny, nz);
        base = 0;
        for (int cyc = 0; cyc < 60 && base <= mx; cyc++) begin
            @(posedge clk); #1;
            if (v4) begin
                nvec++; if (c4 !== CW'(base)) begin nerr++; $display("FAIL l4_count: got %0d want %0d", c4, base); end
                for (int l = 0; l < 4; l++) begin
                    t  = base + l;
                    in = (t <= mx);
                    nvec++;
                    if (m4[l] !== in
                        || t4[l*TW +: TW] !== (in ? TW'(t) : TW'(0))
                        || x4[l*TW +: TW] !== (in ? TW'(ex(t, nx)) : TW'(0))
                        || y4[l*TW +: TW] !== (in ? TW'(ey(t, nx, ny)) : TW'(0))
                        || z4[l*TW +: TW] !== (in ? TW'(ez(t, nx, ny, nz)) : TW'(0))) begin
                        nerr++;
                        $display("FAIL l4_lane%0d tid %0d: got m=%b tid=%0d xyz=(%0d,%0d,%0d) want m=%b xyz=(%0d,%0d,%0d)",
                                 l, t, m4[l], t4[l*TW +: TW], x4[l*TW +: TW], y4[l*TW +: TW], z4[l*TW +: TW],
                                 in, in ? ex(t, nx) : 0, in ? ey(t, nx, ny) : 0, in ? ez(t, nx, ny, nz) : 0);
                    end
                end
                base += 4;
            end
        end
        nvec++; if (base <= mx) begin nerr++; $display("FAIL l4_timeout: got base %0d want > %0d", base, mx); end
        @(posedge clk); #1;
        nvec++; if (d4 !== 1'b1 || b4 !== 1'b0 || v4 !== 1'b0) begin
            nerr++; $display("FAIL l4_done: got done=%b busy=%b valid=%b want 1 0 0", d4, b4, v4);
        end
        nvec++; if (c4 !== CW'(mx + 1)) begin nerr++; $display("FAIL l4_final_count: got %0d want %0d", c4, mx + 1); end
    endtask

    task automatic test_backpressure();
        bit rt [10] = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1};
        bit et [10] = '{1, 0, 0, 0, 0, 1, 1, 0, 0, 1};
        int  nb, t;
        bit  ev, fin;
        do_start(23, 3, 2, 1);
        nb = 0; ev = 1'b0; fin = 1'b0;
        for (int i = 0; i < 40 && !fin; i++) begin
            if (i < 10) begin
                ready = rt[i]; enable = et[i];
            end else begin
                ready = 1'b1; enable = 1'b1;
            end
            @(posedge clk); #1;
            if (ev && ready) begin
                nb += 4;
                fin = (nb > 23);
                ev  = enable && !fin;
            end else if (!ev) begin
                ev = enable;
            end
            nvec++; if (v4 !== ev) begin nerr++; $display("FAIL bp_valid step %0d: got %b want %b", i, v4, ev); end
            if (ev) begin
                for (int l = 0; l < 4; l++) begin
                    t = nb + l;
                    nvec++;
                    if (t4[l*TW +: TW] !== TW'(t) || x4[l*TW +: TW] !== TW'(ex(t, 3))
                        || y4[l*TW +: TW] !== TW'(ey(t, 3, 2)) || z4[l*TW +: TW] !== TW'(ez(t, 3, 2, 1))) begin
                        nerr++;
                        $display("FAIL bp_lane%0d step %0d: got tid=%0d x=%0d want tid=%0d x=%0d",
                                 l, i, t4[l*TW +: TW], x4[l*TW +: TW], t, ex(t, 3));
                    end
                end
            end
        end
        nvec++; if (!fin) begin nerr++; $display("FAIL bp_timeout: got base %0d want 24", nb); end
        nvec++; if (d4 !== 1'b1 || c4 !== CW'(24)) begin
            nerr++; $display("FAIL bp_done: got done=%b count=%0d want 1 24", d4, c4);
        end
        ready = 1'b1; enable = 1'b1;
    endtask

    task automatic test_clr();
        bit seen;
        enable = 1'b1; ready = 1'b1;
        do_start(255, 255, 0, 0);
        seen = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (v1 && t1 == TW'(37)) seen = 1'b1;
        end
        nvec++; if (!seen) begin nerr++; $display("FAIL clr_reach37: got tid %0d want 37", t1); end
        nvec++; if (c1 !== CW'(37)) begin nerr++; $display("FAIL clr_count37: got %0d want 37", c1); end
        clr = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0;
        nvec++; if (v1 !== 1'b0 || b1 !== 1'b0 || d1 !== 1'b0 || c1 !== '0 || m1 !== '0
                    || t1 !== '0 || x1 !== '0 || y1 !== '0 || z1 !== '0) begin
            nerr++; $display("FAIL clr_outputs: got v=%b busy=%b done=%b cnt=%0d tid=%0d want all 0", v1, b1, d1, c1, t1);
        end
        @(posedge clk); #1;
        nvec++; if (v1 !== 1'b0 || b1 !== 1'b0) begin
            nerr++; $display("FAIL clr_idle: got valid=%b busy=%b want 0 0", v1, b1);
        end
        do_start(255, 255, 0, 0);
        @(posedge clk); #1;
        nvec++; if (v1 !== 1'b1 || t1 !== '0 || c1 !== '0) begin
            nerr++; $display("FAIL clr_restart: got valid=%b tid=%0d cnt=%0d want 1 0 0", v1, t1, c1);
        end
    endtask

    task automatic test_lanes8();
        int base, t;
        enable = 1'b1; ready = 1'b1;
        do_start(511, 7, 7, 7);
        base = 0;
        for (int cyc = 0; cyc < 100 && base <= 511; cyc++) begin
            @(posedge clk); #1;
            if (v8) begin
                nvec++; if (m8 !== 8'hFF || c8 !== CW'(base)) begin
                    nerr++; $display("FAIL l8_mask_count: got m=%h cnt=%0d want FF %0d", m8, c8, base);
                end
                for (int l = 0; l < 8; l++) begin
                    t = base + l;
                    nvec++;
                    if (t8[l*TW +: TW] !== TW'(t) || x8[l*TW +: TW] !== TW'(ex(t, 7))
                        || y8[l*TW +: TW] !== TW'(ey(t, 7, 7)) || z8[l*TW +: TW] !== TW'(ez(t, 7, 7, 7))) begin
                        nerr++;
                        $display("FAIL l8_lane%0d: got tid=%0d xyz=(%0d,%0d,%0d) want tid=%0d", l,
                                 t8[l*TW +: TW], x8[l*TW +: TW], y8[l*TW +: TW], z8[l*TW +: TW], t);
                    end
                end
                base += 8;
            end
        end
        nvec++; if (base != 512) begin nerr++; $display("FAIL l8_timeout: got base %0d want 512", base); end
        @(posedge clk); #1;
        nvec++; if (d8 !== 1'b1 || b8 !== 1'b0 || c8 !== CW'(512)) begin
            nerr++; $display("FAIL l8_done: got done=%b busy=%b cnt=%0d want 1 0 512", d8, b8, c8);
        end
    endtask

    initial begin
        test_reset();
        test_lanes1();
        test_lanes4(23, 3, 2, 1);
        test_lanes4(9, 3, 2, 1);
        test_backpressure();
        test_clr();
        test_lanes8();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dice_tid_dispatcher.md
Name: dice_tid_dispatcher

Overview:
Parametrised successor to the naive thread dispatcher. Generates linear thread IDs plus 3D (x,y,z) coordinates for one CTA and issues LANES IDs per beat to the CGRA subsystem. Uses a valid/ready handshake so the CGRA can back-pressure, supports a pause via enable, and flags partial final groups with a lane mask. Sits between kernel metadata/launch control and dice_cgra_subsystem (disp_tid/disp_valid/tid_* inputs).

Parameters:
TOTAL_TID, 512, maximum threads per CTA
TID_WIDTH, $clog2(TOTAL_TID), width of every thread ID / coordinate field
LANES, 1, thread IDs issued per accepted beat (1..8)
CNT_WIDTH, TID_WIDTH+1, width of issued_count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr  in  1  synchronous active-high soft clear, same effect as rst
start  in  1  one-cycle launch pulse; latches the config inputs
enable  in  1  permits presenting new beats (pause when low)
max_tid  in  TID_WIDTH  last linear TID to dispatch, inclusive
ntid_x  in  TID_WIDTH  block extent minus 1 in x (inclusive max index)
ntid_y  in  TID_WIDTH  block extent minus 1 in y
ntid_z  in  TID_WIDTH  block extent minus 1 in z
ready  in  1  downstream accepts the current beat
valid  out  1  beat presented
lane_mask  out  LANES  per-lane valid bit within the beat
dispatch_tid  out  LANES*TID_WIDTH  linear TID per lane, lane 0 in LSBs
tid_x  out  LANES*TID_WIDTH  x coordinate per lane
tid_y  out  LANES*TID_WIDTH  y coordinate per lane
tid_z  out  LANES*TID_WIDTH  z coordinate per lane
busy  out  1  state is RUN
done  out  1  all TIDs 0..max_tid accepted
issued_count  out  CNT_WIDTH  number of lanes accepted since start

Behaviour:
- rst or clr: state IDLE. All outputs 0, base counters 0, latched config 0. clr has priority over start in the same cycle.
- States:
  - IDLE: start latches max_tid and ntid_*, sets base=0 and x=y=z=0, goes to RUN.
  - RUN: runs until the beat containing max_tid is accepted, then goes to DONE.
  - DONE: done=1, valid=0. Holds until clr/rst. start in DONE restarts as from IDLE.
- start in RUN is ignored. Config inputs are sampled only on start.
- All outputs are registered. Earliest valid is the cycle after start (start at edge N means valid=1 after edge N+1 if enable=1).
- valid rises only in RUN with enable=1. Once valid=1, the beat and its fields are held stable until valid&&ready. valid is never retracted, even if enable drops. After an accept with enable=0, valid falls next cycle.
- Accept (valid&&ready): advance to the next beat in the same cycle, so back-to-back beats run at one per cycle while ready=1. Add popcount(lane_mask) to issued_count.
- Lane l: dispatch_tid = base+l, lane_mask[l] = (base+l <= max_tid). Masked lanes drive 0 on all fields.
- Coordinates: lane 0 takes the base coordinates; lane l is lane l-1 incremented in raster order.
  - x increments; at ntid_x, x wraps to 0 and y increments.
  - at ntid_y, y wraps to 0 and z increments.
  - at ntid_z, z wraps to 0.
  - The next base coordinates are lane LANES-1 incremented once.
- The final beat may be partial: the lane_mask upper bits are 0. done asserts the cycle after that beat is accepted, with busy=0 in the same cycle.
- Arithmetic is on TID_WIDTH+1 bits internally, so base+l cannot wrap when max_tid = TOTAL_TID-1.
- max_tid=0 gives a single beat with lane_mask=1. Config with max_tid larger than the block volume wraps z to 0; no error is flagged.

Test Plan:
- LANES=1, ntid_x=255, ntid_y=ntid_z=0, max_tid=255, ready=1, enable=1: 256 consecutive beats, tid 0..255, x=tid, y=z=0; done asserts 1 cycle after the last accept; issued_count=256.
- LANES=4, ntid_x=3, ntid_y=2, ntid_z=1, max_tid=23: 6 beats, all lane_mask=4'hF. Beat 1 lanes are (x,y,z)=(0,1,0),(1,1,0),(2,1,0),(3,1,0). Last lane is (3,2,1); done asserts after.
- LANES=4, max_tid=9: 3 beats; beat 3 is tid 8,9 with lane_mask=4'b0011 and lanes 2-3 all zero; issued_count=10.
- Back-pressure: ready toggled 1,0,0,1 and enable dropped while valid=1 and unaccepted: fields stay stable, valid stays 1 until accepted, no TID skipped or duplicated.
- clr asserted mid-RUN at tid 37 (and with start in the same cycle): next cycle all outputs are 0, state is IDLE; a subsequent start restarts from tid 0.
- max_tid=511, TOTAL_TID=512, LANES=8: 64 beats with no wrap; final beat is tid 504..511 with lane_mask=8'hFF; issued_count=512.
